// File: rtl/sent_tx_channel_pkg.sv
// Shared SENT transmit constants, CRC4 lookup, FSM and config types.
package sent_pkg;

  localparam int SYNC_TICKS        = 56;
  localparam int NIBBLE_BASE_TICKS = 12;
  localparam int MIN_LTICK         = 4;
  localparam int MIN_PAUSE_TICKS   = 12;
  localparam int MAX_FRAME_TICKS   = 272;

  localparam logic [3:0] CRC_SEED = 4'h5;

  // Entry 0 in the low nibble: {T[15], ..., T[0]}
  localparam logic [63:0] CRC4_TABLE = {4'd5, 4'd8, 4'd2, 4'd15, 4'd11, 4'd6, 4'd12, 4'd1,
                                        4'd4, 4'd9, 4'd3, 4'd14, 4'd10, 4'd7, 4'd13, 4'd0};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_STATUS,
    ST_DATA,
    ST_CRC,
    ST_PAUSE
  } state_e;

  typedef enum logic [1:0] {
    PAUSE_NONE     = 2'd0,
    PAUSE_FIXED    = 2'd1,
    PAUSE_ADAPTIVE = 2'd2,
    PAUSE_NONE_ALT = 2'd3
  } pause_mode_e;

  typedef struct packed {
    logic [7:0]  ctick;
    logic [7:0]  ltick;
    pause_mode_e pause_mode;
    logic [15:0] pause_len;
    logic        crc_mode;
    logic [3:0]  status;
    logic [2:0]  data_len;
    logic [23:0] data;
  } sent_cfg_t;

  function automatic logic [3:0] crc4_lut(input logic [3:0] idx);
    return CRC4_TABLE[{idx, 2'b00} +: 4];
  endfunction

  // Nibble i of the payload, n1 (i=0) in the top bits.
  function automatic logic [3:0] nibble_at(input logic [23:0] d, input logic [2:0] i);
    case (i)
      3'd0:    return d[23:20];
      3'd1:    return d[19:16];
      3'd2:    return d[15:12];
      3'd3:    return d[11:8];
      3'd4:    return d[7:4];
      3'd5:    return d[3:0];
      default: return 4'h0;
    endcase
  endfunction

endpackage

// File: rtl/sent_tx_channel_if.sv
// Broadcast configuration bus from the SENT parameter-config stage to each channel.
interface sent_tx_channel_if;
  logic        sent_config_vld;
  logic [7:0]  sent_config_channel;
  logic [7:0]  sent_ctick_len;
  logic [7:0]  sent_ltick_len;
  logic [1:0]  sent_pause_mode;
  logic [15:0] sent_pause_len;
  logic        sent_crc_mode;
  logic [3:0]  sent_status_nibble;
  logic [2:0]  sent_data_len;
  logic [23:0] sent_data_nibble;

  modport master (
    output sent_config_vld, sent_config_channel, sent_ctick_len, sent_ltick_len,
           sent_pause_mode, sent_pause_len, sent_crc_mode, sent_status_nibble,
           sent_data_len, sent_data_nibble
  );

  modport slave (
    input sent_config_vld, sent_config_channel, sent_ctick_len, sent_ltick_len,
          sent_pause_mode, sent_pause_len, sent_crc_mode, sent_status_nibble,
          sent_data_len, sent_data_nibble
  );
endinterface

// File: rtl/sent_tx_channel_crc4.sv
// Sequential SENT CRC4 engine: seed on start, one table step per nibble, optional zero augment.
module sent_crc4
  import sent_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       nibble_vld,
  input  logic [3:0] nibble,
  input  logic       crc_final,
  output logic [3:0] crc_out
);

  logic [3:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (start) begin
      crc_d = CRC_SEED;
    end else if (nibble_vld) begin
      crc_d = crc4_lut(crc_q) ^ nibble;
    end else if (crc_final) begin
      crc_d = crc4_lut(crc_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc_q <= CRC_SEED;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_out = crc_q;

endmodule

// File: rtl/sent_tx_channel.sv
// One SENT (J2716) transmit channel: config capture, tick timing, frame FSM, CRC and pause.
// Optional build macro SENT_TX_FRAME_CNT_EN adds a 16-bit frame counter output.
module sent_tx_channel
  import sent_pkg::*;
#(
  parameter int unsigned CHANNEL_ID = 0,
  parameter int unsigned CLK_FREQ   = 100000000
) (
  input  logic               clk,
  input  logic               rst,
  sent_tx_channel_if.slave   cfg,
  output logic               sent_out,
  output logic               sent_busy,
  output logic               sent_frame_done
`ifdef SENT_TX_FRAME_CNT_EN
  ,
  output logic [15:0]        sent_frame_cnt
`endif
);

  localparam int unsigned CLKS_PER_US = CLK_FREQ / 1000000;

  state_e      state_q, state_d;
  sent_cfg_t   pend_q, pend_d, act_q, act_d;
  logic        pend_vld_q, pend_vld_d;
  logic        armed_q, armed_d;
  logic [16:0] clk_cnt_q, clk_cnt_d;
  logic [16:0] tcnt_q, tcnt_d;
  logic [2:0]  idx_q, idx_d;

  logic        cfg_match, apply, go_next, pause_en;
  logic        tick, pulse_end, frame_done;
  logic [16:0] tick_clks, pulse_ticks, frame_ticks, pause_raw, pause_ticks;
  logic [3:0]  cur_nib, crc_out;
  logic        crc_start, crc_nvld, crc_fin;

  function automatic sent_cfg_t sanitize(input sent_cfg_t c);
    sent_cfg_t s;
    s = c;
    if (c.ltick < 8'(MIN_LTICK)) s.ltick = 8'(MIN_LTICK);
    if (c.data_len == 3'd0) s.data_len = 3'd1;
    else if (c.data_len > 3'd6) s.data_len = 3'd6;
    return s;
  endfunction

  assign cfg_match = cfg.sent_config_vld && (cfg.sent_config_channel == 8'(CHANNEL_ID));

  always_comb begin
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (apply) pend_vld_d = 1'b0;
    if (cfg_match) begin
      pend_vld_d          = 1'b1;
      pend_d.ctick        = cfg.sent_ctick_len;
      pend_d.ltick        = cfg.sent_ltick_len;
      pend_d.pause_mode   = pause_mode_e'(cfg.sent_pause_mode);
      pend_d.pause_len    = cfg.sent_pause_len;
      pend_d.crc_mode     = cfg.sent_crc_mode;
      pend_d.status       = cfg.sent_status_nibble;
      pend_d.data_len     = cfg.sent_data_len;
      pend_d.data         = cfg.sent_data_nibble;
    end
  end

  // Pending config only lands between frames, so a frame never changes shape mid-flight.
  assign apply   = pend_vld_q && ((state_q == ST_IDLE) || frame_done);
  assign go_next = apply ? (pend_q.ctick != 8'd0) : armed_q;
  assign act_d   = apply ? sanitize(pend_q) : act_q;
  assign armed_d = apply ? (pend_q.ctick != 8'd0) : armed_q;

  assign tick_clks = 17'(act_q.ctick * CLKS_PER_US);
  assign cur_nib   = nibble_at(act_q.data, idx_q);
  assign pause_en  = (act_q.pause_mode == PAUSE_FIXED) || (act_q.pause_mode == PAUSE_ADAPTIVE);

  always_comb begin
    frame_ticks = 17'(SYNC_TICKS) + 17'(NIBBLE_BASE_TICKS) * (17'(act_q.data_len) + 17'd2)
                + 17'(act_q.status) + 17'(crc_out);
    for (int i = 0; i < 6; i++) begin
      if (i < int'(act_q.data_len)) frame_ticks = frame_ticks + 17'(nibble_at(act_q.data, 3'(i)));
    end
    case (act_q.pause_mode)
      PAUSE_FIXED:    pause_raw = 17'(act_q.pause_len);
      PAUSE_ADAPTIVE: pause_raw = 17'(MAX_FRAME_TICKS) + 17'(act_q.pause_len) - frame_ticks;
      default:        pause_raw = '0;
    endcase
    pause_ticks = (pause_raw < 17'(MIN_PAUSE_TICKS)) ? 17'(MIN_PAUSE_TICKS) : pause_raw;
  end

  always_comb begin
    case (state_q)
      ST_SYNC:   pulse_ticks = 17'(SYNC_TICKS);
      ST_STATUS: pulse_ticks = 17'(NIBBLE_BASE_TICKS) + 17'(act_q.status);
      ST_DATA:   pulse_ticks = 17'(NIBBLE_BASE_TICKS) + 17'(cur_nib);
      ST_CRC:    pulse_ticks = 17'(NIBBLE_BASE_TICKS) + 17'(crc_out);
      ST_PAUSE:  pulse_ticks = pause_ticks;
      default:   pulse_ticks = 17'd1;
    endcase
  end

  assign tick       = (state_q != ST_IDLE) && (clk_cnt_q == tick_clks - 17'd1);
  assign pulse_end  = tick && (tcnt_q == pulse_ticks - 17'd1);
  assign frame_done = pulse_end && ((state_q == ST_PAUSE) || ((state_q == ST_CRC) && !pause_en));

  // CRC runs on tick strobes during SYNC; 56 ticks leaves ample room for 6 nibbles plus augment.
  assign crc_start = tick && (state_q == ST_SYNC) && (tcnt_q == 17'd0);
  assign crc_nvld  = tick && (state_q == ST_SYNC) && (tcnt_q >= 17'd1)
                   && (tcnt_q <= 17'(act_q.data_len));
  assign crc_fin   = tick && (state_q == ST_SYNC) && act_q.crc_mode
                   && (tcnt_q == 17'(act_q.data_len) + 17'd1);

  sent_crc4 u_crc (
    .clk        (clk),
    .rst        (rst),
    .start      (crc_start),
    .nibble_vld (crc_nvld),
    .nibble     (nibble_at(act_q.data, 3'(tcnt_q - 17'd1))),
    .crc_final  (crc_fin),
    .crc_out    (crc_out)
  );

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    tcnt_d    = tcnt_q;
    idx_d     = idx_q;
    if (state_q == ST_IDLE) begin
      clk_cnt_d = '0;
      tcnt_d    = '0;
      idx_d     = '0;
      if (go_next) state_d = ST_SYNC;
    end else begin
      clk_cnt_d = tick ? 17'd0 : clk_cnt_q + 17'd1;
      if (tick) tcnt_d = pulse_end ? 17'd0 : tcnt_q + 17'd1;
      if (pulse_end) begin
        case (state_q)
          ST_SYNC:   state_d = ST_STATUS;
          ST_STATUS: begin
            state_d = ST_DATA;
            idx_d   = '0;
          end
          ST_DATA: begin
            if (idx_q == act_q.data_len - 3'd1) state_d = ST_CRC;
            else idx_d = idx_q + 3'd1;
          end
          ST_CRC:    state_d = pause_en ? ST_PAUSE : (go_next ? ST_SYNC : ST_IDLE);
          ST_PAUSE:  state_d = go_next ? ST_SYNC : ST_IDLE;
          default:   state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      act_q      <= '0;
      armed_q    <= 1'b0;
      clk_cnt_q  <= '0;
      tcnt_q     <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      act_q      <= act_d;
      armed_q    <= armed_d;
      clk_cnt_q  <= clk_cnt_d;
      tcnt_q     <= tcnt_d;
      idx_q      <= idx_d;
    end
  end

  // Low phase is the first ltick ticks of every pulse; ltick >= pulse length keeps it low throughout.
  assign sent_out        = !((state_q != ST_IDLE) && (tcnt_q < 17'(act_q.ltick)));
  assign sent_busy       = (state_q != ST_IDLE);
  assign sent_frame_done = frame_done;

`ifdef SENT_TX_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  assign frame_cnt_d = frame_done ? frame_cnt_q + 16'd1 : frame_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign sent_frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_sent_tx_channel.sv
// Directed bench for sent_tx_channel: table of frame configs plus hand-written corner sequences.
module tb_sent_tx_channel;

  localparam int MHZ      = 2;
  localparam int CLK_FREQ = MHZ * 1000000;
  localparam int LIM      = 20000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sent_out, sent_busy, sent_frame_done;
`ifdef SENT_TX_FRAME_CNT_EN
  logic [15:0] sent_frame_cnt;
`endif

  sent_tx_channel_if cfg_if ();

  sent_tx_channel #(.CHANNEL_ID(0), .CLK_FREQ(CLK_FREQ)) dut (
    .clk             (clk),
    .rst             (rst),
    .cfg             (cfg_if),
    .sent_out        (sent_out),
    .sent_busy       (sent_busy),
    .sent_frame_done (sent_frame_done)
`ifdef SENT_TX_FRAME_CNT_EN
    ,
    .sent_frame_cnt  (sent_frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  ctick;
    logic [7:0]  ltick;
    logic [1:0]  pmode;
    logic [15:0] plen;
    logic        crc_mode;
    logic [3:0]  status;
    logic [2:0]  len;
    logic [23:0] data;
    int          exp_ltick;
    int          exp_len;
    int          exp_crc;
    int          exp_pause;
    int          exp_period;
  } vec_t;

  vec_t vecs [7];
  vec_t vmid, vzero;

  int tests_run    = 0;
  int tests_failed = 0;
  int done_cnt     = 0;

  always @(negedge clk) if (sent_frame_done === 1'b1) done_cnt <= done_cnt + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected summary before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int nib(input logic [23:0] d, input int i);
    logic [23:0] s;
    s = d >> (20 - 4 * i);
    return int'(s[3:0]);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_cfg(input vec_t v, input logic [7:0] ch);
    @(negedge clk);
    cfg_if.sent_config_channel = ch;
    cfg_if.sent_ctick_len      = v.ctick;
    cfg_if.sent_ltick_len      = v.ltick;
    cfg_if.sent_pause_mode     = v.pmode;
    cfg_if.sent_pause_len      = v.plen;
    cfg_if.sent_crc_mode       = v.crc_mode;
    cfg_if.sent_status_nibble  = v.status;
    cfg_if.sent_data_len       = v.len;
    cfg_if.sent_data_nibble    = v.data;
    cfg_if.sent_config_vld     = 1'b1;
    @(negedge clk);
    cfg_if.sent_config_vld     = 1'b0;
  endtask

  // Config at cycle N: line still high at N+1, low from N+2.
  task automatic start_frame(input vec_t v, input string tag);
    send_cfg(v, 8'd0);
    check({tag, " lat_n1_out"}, int'(sent_out), 1);
    @(negedge clk);
    check({tag, " lat_n2_out"}, int'(sent_out), 0);
    check({tag, " lat_n2_busy"}, int'(sent_busy), 1);
  endtask

  task automatic measure_pulse(output int lo, output int per, output int last_done);
    int hi;
    lo = 0;
    hi = 0;
    last_done = 0;
    while (sent_out === 1'b0 && lo < LIM) begin
      lo++;
      @(negedge clk);
    end
    while (sent_out === 1'b1 && sent_busy === 1'b1 && hi < LIM) begin
      hi++;
      last_done = int'(sent_frame_done);
      @(negedge clk);
    end
    per = lo + hi;
  endtask

  task automatic measure_frame(input vec_t v, input string tag);
    int tc, lo, per, ld, total;
    tc = int'(v.ctick) * MHZ;
    total = 0;
    measure_pulse(lo, per, ld);
    check({tag, " sync_low"}, lo, v.exp_ltick * tc);
    check({tag, " sync_per"}, per, 56 * tc);
    total += per;
    measure_pulse(lo, per, ld);
    check({tag, " status_per"}, per, (12 + int'(v.status)) * tc);
    total += per;
    for (int i = 0; i < v.exp_len; i++) begin
      measure_pulse(lo, per, ld);
      check($sformatf("%s data%0d_per", tag, i), per, (12 + nib(v.data, i)) * tc);
      check($sformatf("%s data%0d_low", tag, i), lo, v.exp_ltick * tc);
      total += per;
    end
    measure_pulse(lo, per, ld);
    check({tag, " crc_per"}, per, v.exp_crc * tc);
    total += per;
    if (v.exp_pause != 0) begin
      measure_pulse(lo, per, ld);
      check({tag, " pause_per"}, per, v.exp_pause * tc);
      total += per;
    end
    check({tag, " done_at_end"}, ld, 1);
    check({tag, " frame_per"}, total, v.exp_period * tc);
  endtask

  initial begin
    int lows, d0;
    cfg_if.sent_config_vld     = 1'b0;
    cfg_if.sent_config_channel = '0;
    cfg_if.sent_ctick_len      = '0;
    cfg_if.sent_ltick_len      = '0;
    cfg_if.sent_pause_mode     = '0;
    cfg_if.sent_pause_len      = '0;
    cfg_if.sent_crc_mode       = 1'b0;
    cfg_if.sent_status_nibble  = '0;
    cfg_if.sent_data_len       = '0;
    cfg_if.sent_data_nibble    = '0;

    //          ctick  ltick pm    plen    crc   stat   len   data        lt len crc pause period
    vecs[0] = '{8'd3, 8'd4, 2'd0, 16'd0,  1'b0, 4'h0, 3'd6, 24'h123456, 4, 6, 25, 0,   186};
    vecs[1] = '{8'd3, 8'd4, 2'd0, 16'd0,  1'b1, 4'h0, 3'd6, 24'h123456, 4, 6, 14, 0,   175};
    vecs[2] = '{8'd3, 8'd4, 2'd1, 16'd12, 1'b0, 4'h0, 3'd6, 24'h123456, 4, 6, 25, 12,  198};
    vecs[3] = '{8'd3, 8'd4, 2'd2, 16'd12, 1'b0, 4'h0, 3'd6, 24'h123456, 4, 6, 25, 98,  284};
    vecs[4] = '{8'd3, 8'd2, 2'd0, 16'd0,  1'b0, 4'h0, 3'd0, 24'h123456, 4, 1, 14, 0,   95};
    vecs[5] = '{8'd4, 8'd5, 2'd3, 16'd0,  1'b0, 4'hA, 3'd3, 24'hF0F000, 5, 3, 22, 0,   166};
    vecs[6] = '{8'd3, 8'd4, 2'd2, 16'd0,  1'b1, 4'h0, 3'd7, 24'h000000, 4, 6, 17, 115, 272};
    vmid    = '{8'd3, 8'd4, 2'd0, 16'd0,  1'b1, 4'h3, 3'd6, 24'h123456, 4, 6, 14, 0,   178};
    vzero   = '{8'd0, 8'd4, 2'd0, 16'd0,  1'b0, 4'h0, 3'd1, 24'h123456, 4, 1, 14, 0,   95};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_out", int'(sent_out), 1);
    check("reset_busy", int'(sent_busy), 0);
    check("reset_done", int'(sent_frame_done), 0);
`ifdef SENT_TX_FRAME_CNT_EN
    check("reset_frame_cnt", int'(sent_frame_cnt), 0);
`endif
    rst = 1'b0;

    // Config for another channel is ignored
    send_cfg(vecs[0], 8'd1);
    lows = 0;
    repeat (40) begin
      @(negedge clk);
      if (sent_out !== 1'b1) lows++;
    end
    check("other_channel_lows", lows, 0);
    check("other_channel_busy", int'(sent_busy), 0);

    for (int i = 0; i < 7; i++) begin
      do_reset();
      start_frame(vecs[i], $sformatf("v%0d", i));
      measure_frame(vecs[i], $sformatf("v%0d", i));
    end

    // Mid-frame reconfig takes effect only on the next frame
    do_reset();
    start_frame(vecs[0], "mid");
    fork
      measure_frame(vecs[0], "mid_old");
      begin
        repeat (30) @(negedge clk);
        send_cfg(vmid, 8'd0);
      end
    join
    measure_frame(vmid, "mid_new");

    // ctick=0 parks the channel after the running frame
    do_reset();
    start_frame(vecs[4], "ct0");
    fork
      measure_frame(vecs[4], "ct0_frame");
      begin
        repeat (30) @(negedge clk);
        send_cfg(vzero, 8'd0);
      end
    join
    check("ct0_busy_after", int'(sent_busy), 0);
    lows = 0;
    repeat (40) begin
      @(negedge clk);
      if (sent_out !== 1'b1) lows++;
    end
    check("ct0_idle_lows", lows, 0);

    // Reset in the middle of the first data nibble
    do_reset();
    start_frame(vecs[0], "rstmid");
    repeat (71 * 3 * MHZ) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_out", int'(sent_out), 1);
    check("rstmid_busy", int'(sent_busy), 0);
    check("rstmid_done", int'(sent_frame_done), 0);
    rst = 1'b0;
    d0 = done_cnt;
    lows = 0;
    repeat (60) begin
      @(negedge clk);
      if (sent_out !== 1'b1) lows++;
    end
    check("rstmid_idle_lows", lows, 0);
    check("rstmid_no_done", done_cnt - d0, 0);

    // Three back-to-back frames
    do_reset();
    d0 = done_cnt;
    start_frame(vecs[0], "cnt");
    for (int f = 0; f < 3; f++) measure_frame(vecs[0], $sformatf("cnt_f%0d", f));
    check("cnt_done_pulses", done_cnt - d0, 3);
`ifdef SENT_TX_FRAME_CNT_EN
    check("cnt_frame_cnt", int'(sent_frame_cnt), 3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
